// File: rtl/rule_priority_merge.sv
// Two-lane lowest-rule-ID merge: 3 pipelines -> min per lane, queued
// in show-ahead FIFOs with drop/miss statistics. Ports per lane L=1,2.
module rule_priority_merge_lane #(
  parameter int RULE_ID    = 14,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic [RULE_ID-1:0]   rule0,
  input  logic                 act0,
  input  logic [RULE_ID-1:0]   rule1,
  input  logic                 act1,
  input  logic [RULE_ID-1:0]   rule2,
  input  logic                 act2,
  input  logic                 valid,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [RULE_ID-1:0]   out_rule,
  output logic                 out_hit,
  output logic [CNT_WIDTH-1:0] drop_cnt,
  output logic [CNT_WIDTH-1:0] miss_cnt
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  logic [RULE_ID-1:0] a01;
  logic               a01_v;
  logic               s1_valid;
  logic               s1_a01_v;
  logic [RULE_ID-1:0] s1_a01;
  logic               s1_p2_v;
  logic [RULE_ID-1:0] s1_p2;
  logic [RULE_ID-1:0] res_rule;
  logic               res_hit;

  always_comb begin
    a01_v = act0 | act1;
    a01   = rule0;
    if (act1 && (!act0 || rule1 < rule0))
      a01 = rule1;
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      s1_valid <= 1'b0;
      s1_a01_v <= 1'b0;
      s1_a01   <= '0;
      s1_p2_v  <= 1'b0;
      s1_p2    <= '0;
    end else begin
      s1_valid <= valid;
      s1_a01_v <= a01_v;
      s1_a01   <= a01;
      s1_p2_v  <= act2;
      s1_p2    <= rule2;
    end
  end

  // S2 result is registered directly into the FIFO entry, which keeps
  // the input-to-out_valid latency at two clocks.
  always_comb begin
    res_hit  = s1_a01_v | s1_p2_v;
    res_rule = '1;
    if (s1_a01_v && (!s1_p2_v || s1_a01 <= s1_p2))
      res_rule = s1_a01;
    else if (s1_p2_v)
      res_rule = s1_p2;
  end

  logic [RULE_ID:0] mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             full;
  logic             pop;
  logic             wr;
  logic             drop;
  logic [RULE_ID:0] head;

  assign full = (count == FULL);
  assign pop  = (count != '0) && out_ready;
  // When full, a same-cycle pop frees the slot the write needs.
  assign wr   = s1_valid && (!full || pop);
  assign drop = s1_valid && full && !pop;

  always_ff @(posedge clk) begin
    if (wr)
      mem[wr_ptr] <= {res_hit, res_rule};
  end

  always_ff @(posedge clk or negedge RSTn) begin
    if (!RSTn) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      drop_cnt <= '0;
      miss_cnt <= '0;
    end else begin
      if (wr)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      unique case ({wr, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (drop && drop_cnt != '1)
        drop_cnt <= drop_cnt + 1'b1;
      if (s1_valid && !res_hit && miss_cnt != '1)
        miss_cnt <= miss_cnt + 1'b1;
    end
  end

  assign head      = mem[rd_ptr];
  assign out_valid = (count != '0);
  assign out_rule  = out_valid ? head[RULE_ID-1:0] : '0;
  assign out_hit   = out_valid ? head[RULE_ID] : 1'b0;
endmodule

module rule_priority_merge #(
  parameter int RULE_ID    = 14,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                 clk,
  input  logic                 RSTn,
  input  logic [RULE_ID-1:0]   rule_pipe0_in1,
  input  logic [RULE_ID-1:0]   rule_pipe1_in1,
  input  logic [RULE_ID-1:0]   rule_pipe2_in1,
  input  logic [RULE_ID-1:0]   rule_pipe0_in2,
  input  logic [RULE_ID-1:0]   rule_pipe1_in2,
  input  logic [RULE_ID-1:0]   rule_pipe2_in2,
  input  logic                 act_valid_pipe0_in1,
  input  logic                 act_valid_pipe1_in1,
  input  logic                 act_valid_pipe2_in1,
  input  logic                 act_valid_pipe0_in2,
  input  logic                 act_valid_pipe1_in2,
  input  logic                 act_valid_pipe2_in2,
  input  logic                 valid_pipe0_in1,
  input  logic                 valid_pipe0_in2,
  output logic                 out_valid_1,
  output logic                 out_valid_2,
  input  logic                 out_ready_1,
  input  logic                 out_ready_2,
  output logic [RULE_ID-1:0]   out_rule_1,
  output logic [RULE_ID-1:0]   out_rule_2,
  output logic                 out_hit_1,
  output logic                 out_hit_2,
  output logic [CNT_WIDTH-1:0] drop_cnt_1,
  output logic [CNT_WIDTH-1:0] drop_cnt_2,
  output logic [CNT_WIDTH-1:0] miss_cnt_1,
  output logic [CNT_WIDTH-1:0] miss_cnt_2
);
  rule_priority_merge_lane #(
    .RULE_ID(RULE_ID), .FIFO_DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_lane1 (
    .clk(clk), .RSTn(RSTn),
    .rule0(rule_pipe0_in1), .act0(act_valid_pipe0_in1),
    .rule1(rule_pipe1_in1), .act1(act_valid_pipe1_in1),
    .rule2(rule_pipe2_in1), .act2(act_valid_pipe2_in1),
    .valid(valid_pipe0_in1),
    .out_valid(out_valid_1), .out_ready(out_ready_1),
    .out_rule(out_rule_1), .out_hit(out_hit_1),
    .drop_cnt(drop_cnt_1), .miss_cnt(miss_cnt_1)
  );

  rule_priority_merge_lane #(
    .RULE_ID(RULE_ID), .FIFO_DEPTH(FIFO_DEPTH), .CNT_WIDTH(CNT_WIDTH)
  ) u_lane2 (
    .clk(clk), .RSTn(RSTn),
    .rule0(rule_pipe0_in2), .act0(act_valid_pipe0_in2),
    .rule1(rule_pipe1_in2), .act1(act_valid_pipe1_in2),
    .rule2(rule_pipe2_in2), .act2(act_valid_pipe2_in2),
    .valid(valid_pipe0_in2),
    .out_valid(out_valid_2), .out_ready(out_ready_2),
    .out_rule(out_rule_2), .out_hit(out_hit_2),
    .drop_cnt(drop_cnt_2), .miss_cnt(miss_cnt_2)
  );
endmodule
